// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pc_fetch_ctrl                                                  |
// | Brief   : MIPS fetch sequencer: PC register, imem handshake, delay-slot  |
// |           redirects and a 1-entry skid buffer toward IF/ID.              |
// |           Optional: PC_FETCH_ALIGN_CHK_EN (misaligned-redirect check).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        align_err
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SKID = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc_q;
  logic        r_pend_v;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_valid_f;
  logic [31:0] r_instr_f;
  logic [31:0] r_pc_f;

  logic        w_transfer;
  logic        w_slot_free;
  logic        w_advance;
  logic        w_load_out;
  logic        w_load_skid;
  logic        w_unload_skid;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_pc_nxt;

`ifdef PC_FETCH_ALIGN_CHK_EN
  logic        r_align_err;

  assign w_redir_tgt = {redirect_target[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_align_err <= 1'b0;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      r_align_err <= 1'b1;
    end
  end

  assign align_err = r_align_err;
`else
  assign w_redir_tgt = redirect_target;
  assign align_err   = 1'b0;
`endif

  assign w_transfer  = r_valid_f & ~stall;
  assign w_slot_free = ~r_valid_f | w_transfer;

  // A fresh redirect beats an older pending one (newest wins).
  assign w_pc_nxt = redirect_valid ? w_redir_tgt :
                    (r_pend_v ? r_pend_tgt : (r_pc_q + c_PC_STEP));

  always_comb begin
    w_state_nxt   = r_state;
    w_advance     = 1'b0;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_unload_skid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          w_advance = 1'b1;
          if (w_slot_free) begin
            w_load_out = 1'b1;
          end else begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        if (w_transfer) begin
          w_unload_skid = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirects never squash fetched words: the held/in-flight one is the delay slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_q     <= RESET_PC;
      r_pend_v   <= 1'b0;
      r_pend_tgt <= 32'd0;
    end else if (w_advance) begin
      r_pc_q   <= w_pc_nxt;
      r_pend_v <= 1'b0;
    end else if (redirect_valid) begin
      r_pend_v   <= 1'b1;
      r_pend_tgt <= w_redir_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skid_instr <= 32'd0;
      r_skid_pc    <= RESET_PC;
    end else if (w_load_skid) begin
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_f <= 1'b0;
      r_instr_f <= 32'd0;
      r_pc_f    <= RESET_PC;
    end else if (w_load_out) begin
      r_valid_f <= 1'b1;
      r_instr_f <= imem_rdata;
      r_pc_f    <= r_pc_q;
    end else if (w_unload_skid) begin
      r_valid_f <= 1'b1;
      r_instr_f <= r_skid_instr;
      r_pc_f    <= r_skid_pc;
    end else if (w_transfer) begin
      r_valid_f <= 1'b0;
    end
  end

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_pc_q;
  assign valid_f   = r_valid_f;
  assign instr_f   = r_instr_f;
  assign pc_f      = r_pc_f;

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer for the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory request/ack handshake.
- Applies redirects (branch/jal/jr targets already computed by the next-PC logic) with MIPS delay-slot semantics.
- Delivers fetched instructions to the IF/ID boundary under hazard-unit stalls, using a 1-entry skid buffer.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit holds IF/ID; decode not accepting.
- redirect_valid  input  1  one-cycle pulse: control transfer resolved in D.
- redirect_target  input  32  target PC for redirect_valid.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  response valid; may be same cycle as req or any later cycle.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- valid_f  output  1  instr_f/pc_f hold a valid instruction.
- instr_f  output  32  fetched instruction to IF/ID.
- pc_f  output  32  PC of instr_f.
- align_err  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC; state=IDLE; imem_req=0; valid_f=0; instr_f=0; pc_f=RESET_PC.
  - Skid buffer and pending redirect cleared; align_err=0.
- Transfer to decode occurs at a rising edge when valid_f=1 and stall=0.
- Output slot free: valid_f=0, or a transfer is occurring this cycle.
- States:
  - IDLE: one cycle after reset release, unconditionally -> REQ.
  - REQ: imem_req=1, imem_addr=pc_q.
    - Without ack: stay in REQ; imem_addr must not change.
    - With ack and output slot free: instr_f<=imem_rdata, pc_f<=pc_q, valid_f<=1; advance PC; stay in REQ. Zero-wait memory gives 1 instr/cycle.
    - With ack and output slot not free: capture rdata/pc into the skid buffer; advance PC; -> SKID.
  - SKID: imem_req=0. On transfer, the skid contents move to instr_f/pc_f (valid_f stays 1); -> REQ next cycle.
- Advance PC: pc_q <= redirect_valid ? redirect_target : (pend_v ? pend_tgt : pc_q+4); pend_v<=0.
- Delay slot: a redirect never kills the in-flight or held instruction; that instruction is the delay slot.
- Redirect arriving when no PC advance occurs that cycle: latch pend_v=1, pend_tgt=redirect_target.
- A second redirect while pend_v=1 overwrites pend_tgt (newest wins).
- A redirect coincident with an advance is used directly and is not latched.
- pc_q+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- stall never drops imem_req once it is asserted in REQ; the response lands in the skid buffer.
- Reset mid-request: all state cleared; a late imem_ack after reset is ignored (state IDLE).

Optional Feature:
- Macro: PC_FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect whose target[1:0]!=0 sets align_err=1, sticky until reset.
  - The target is used with bits [1:0] forced to 00.
- Undefined:
  - align_err tied 0.
  - redirect_target used unmodified; no check logic.

Test Plan:
- Reset, zero-wait memory (ack=req), stall=0 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; pc_f follows one cycle later; valid_f=1 from the cycle after the first ack.
- Ack delayed 3 cycles on 0x3004 -> imem_req and imem_addr=0x3004 held 4 cycles; no pc_f change; next address 0x3008.
- stall=1 for 4 cycles, valid_f=1, ack on 0x3008 -> skid holds 0x3008, imem_req=0 in SKID; after stall drops, pc_f sequence 0x3004, 0x3008, then fetch 0x300C.
- redirect_valid with target 0x3100 while fetch of 0x300C is waiting for ack -> 0x300C delivered (delay slot); next imem_addr=0x3100; pend_v cleared.
- Redirect coincident with ack of 0x3010 -> next addr 0x3100 without a pending latch; second redirect during a stalled period -> last target fetched.
- With PC_FETCH_ALIGN_CHK_EN: redirect target 0x3102 -> fetch 0x3100, align_err=1 persists until reset; without the macro, align_err stays 0.
